// File: rtl/micro_step_sequencer.sv
// micro_step_sequencer: sequences one instruction through the shared ALU datapath.
// Fetches the instruction word, latches the decoder's per-step codes, replays up to
// three micro-steps onto the single reg_load/select bus, then advances EIP.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN (unknown opcode halts until reset).
module micro_step_sequencer #(
    parameter int unsigned STEP_WAIT    = 0,
    parameter logic [3:0]  EIP_REG_CODE = 4'h4
) (
    input  logic        clk2,
    input  logic        reset,
    input  logic [31:0] ope,
    input  logic        fetch_ack,
    input  logic [3:0]  reg_load_1,
    input  logic [3:0]  reg_load_2,
    input  logic [3:0]  reg_load_3,
    input  logic [3:0]  select_1,
    input  logic [3:0]  select_2,
    input  logic [3:0]  select_3,
    input  logic [3:0]  num_of_ope,
    output logic        fetch_req,
    output logic [3:0]  reg_load,
    output logic [3:0]  select,
    output logic        alu_en,
    output logic [1:0]  step_idx,
    output logic [3:0]  eip_add,
    output logic        eip_add_en,
    output logic        busy,
    output logic        illegal
);

    localparam logic [2:0] WaitLast = 3'(STEP_WAIT);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StAdvance, StHalt} state_e;

    state_e     state_q, state_d;
    logic       run_q;
    logic [7:0] op_q;
    logic [3:0] rl1_q, rl2_q, rl3_q;
    logic [3:0] sel1_q, sel2_q, sel3_q;
    logic [3:0] num_q;
    logic [1:0] n_q;
    logic [1:0] k_q, k_d;
    logic [2:0] wait_q, wait_d;
    logic       ew_q, ew_d;
    logic [1:0] steps;
    logic [3:0] cur_rl, cur_sel;

    // Only the opcode byte matters here; the operand bytes belong to the decoder.
    logic unused_ope;
    assign unused_ope = ^ope[23:0];

    // Step count per opcode; zero marks an unknown opcode.
    always_comb begin
        unique case (op_q)
            8'h55:   steps = 2'd2;
            8'h89:   steps = 2'd1;
            8'hb8:   steps = 2'd1;
            8'h5d:   steps = 2'd2;
            8'hc3:   steps = 2'd2;
            8'he2:   steps = 2'd3;
            default: steps = 2'd0;
        endcase
    end

    // Pick the latched codes of the active step.
    always_comb begin
        cur_rl  = 4'h0;
        cur_sel = 4'h0;
        case (k_q)
            2'd1:    begin cur_rl = rl1_q; cur_sel = sel1_q; end
            2'd2:    begin cur_rl = rl2_q; cur_sel = sel2_q; end
            2'd3:    begin cur_rl = rl3_q; cur_sel = sel3_q; end
            default: begin cur_rl = 4'h0;  cur_sel = 4'h0;   end
        endcase
    end

    // State, counters and latched decoder codes; reset clears everything.
    always_ff @(posedge clk2) begin
        if (!reset) begin
            state_q <= StFetch;
            run_q   <= 1'b0;
            op_q    <= 8'h00;
            rl1_q   <= 4'h0;
            rl2_q   <= 4'h0;
            rl3_q   <= 4'h0;
            sel1_q  <= 4'h0;
            sel2_q  <= 4'h0;
            sel3_q  <= 4'h0;
            num_q   <= 4'h0;
            n_q     <= 2'd0;
            k_q     <= 2'd0;
            wait_q  <= 3'd0;
            ew_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            k_q     <= k_d;
            wait_q  <= wait_d;
            ew_q    <= ew_d;
            if (state_q == StFetch && run_q && fetch_ack) begin
                op_q <= ope[31:24];
            end
            if (state_q == StDecode) begin
                rl1_q  <= reg_load_1;
                rl2_q  <= reg_load_2;
                rl3_q  <= reg_load_3;
                sel1_q <= select_1;
                sel2_q <= select_2;
                sel3_q <= select_3;
                n_q    <= steps;
                // An unknown opcode (non-trapping build) advances EIP by one byte.
                num_q  <= (steps == 2'd0) ? 4'h1 : num_of_ope;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wait_d     = wait_q;
        ew_d       = ew_q;
        fetch_req  = 1'b0;
        reg_load   = 4'h0;
        select     = 4'h0;
        alu_en     = 1'b0;
        step_idx   = 2'd0;
        eip_add    = 4'h0;
        eip_add_en = 1'b0;
        busy       = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            StFetch: begin
                // run_q keeps fetch_req low in the cycle right after reset.
                fetch_req = run_q;
                if (run_q && fetch_ack) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                busy = 1'b1;
                if (steps == 2'd0) begin
                    illegal = 1'b1;
`ifdef SEQ_ILLEGAL_TRAP_EN
                    state_d = StHalt;
`else
                    state_d = StAdvance;
`endif
                end else begin
                    state_d = StExec;
                    k_d     = 2'd1;
                    wait_d  = 3'd0;
                end
            end
            StExec: begin
                busy     = 1'b1;
                reg_load = cur_rl;
                select   = cur_sel;
                step_idx = k_q;
                if (wait_q == WaitLast) begin
                    alu_en = 1'b1;
                    wait_d = 3'd0;
                    if (cur_rl == EIP_REG_CODE) begin
                        ew_d = 1'b1;
                    end
                    if (k_q < n_q) begin
                        k_d = k_q + 2'd1;
                    end else begin
                        k_d     = 2'd0;
                        state_d = StAdvance;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            StAdvance: begin
                busy = 1'b1;
                if (!ew_q) begin
                    eip_add_en = 1'b1;
                    eip_add    = num_q;
                end
                ew_d    = 1'b0;
                state_d = StFetch;
            end
            StHalt: begin
                busy    = 1'b1;
                illegal = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_micro_step_sequencer.sv
// Directed bench for micro_step_sequencer: a table of instructions on a STEP_WAIT=0
// instance plus hand-written sequences for wait states, illegal opcode and abort.
module tb_micro_step_sequencer;

    logic        clk2 = 1'b0;
    logic        reset;
    logic [31:0] ope;
    logic        fetch_ack;
    logic [3:0]  reg_load_1, reg_load_2, reg_load_3;
    logic [3:0]  select_1, select_2, select_3;
    logic [3:0]  num_of_ope;

    logic        fr0, alu0, en0, busy0, ill0;
    logic [3:0]  rl0, sel0, add0;
    logic [1:0]  idx0;
    logic        fr2, alu2, en2, busy2, ill2;
    logic [3:0]  rl2, sel2, add2;
    logic [1:0]  idx2;

    int errors = 0;
    int checks = 0;

    always #5 clk2 = ~clk2;

    micro_step_sequencer #(.STEP_WAIT(0)) dut0 (
        .clk2(clk2), .reset(reset), .ope(ope), .fetch_ack(fetch_ack),
        .reg_load_1(reg_load_1), .reg_load_2(reg_load_2), .reg_load_3(reg_load_3),
        .select_1(select_1), .select_2(select_2), .select_3(select_3),
        .num_of_ope(num_of_ope), .fetch_req(fr0), .reg_load(rl0), .select(sel0),
        .alu_en(alu0), .step_idx(idx0), .eip_add(add0), .eip_add_en(en0),
        .busy(busy0), .illegal(ill0)
    );

    micro_step_sequencer #(.STEP_WAIT(2)) dut2 (
        .clk2(clk2), .reset(reset), .ope(ope), .fetch_ack(fetch_ack),
        .reg_load_1(reg_load_1), .reg_load_2(reg_load_2), .reg_load_3(reg_load_3),
        .select_1(select_1), .select_2(select_2), .select_3(select_3),
        .num_of_ope(num_of_ope), .fetch_req(fr2), .reg_load(rl2), .select(sel2),
        .alu_en(alu2), .step_idx(idx2), .eip_add(add2), .eip_add_en(en2),
        .busy(busy2), .illegal(ill2)
    );

    // Observation vector: {fetch_req, reg_load, select, alu_en, step_idx, eip_add,
    // eip_add_en, busy, illegal}
    logic [18:0] obs0, obs2;
    assign obs0 = {fr0, rl0, sel0, alu0, idx0, add0, en0, busy0, ill0};
    assign obs2 = {fr2, rl2, sel2, alu2, idx2, add2, en2, busy2, ill2};

    function automatic logic [18:0] mk(input logic fr, input logic [3:0] rl,
                                       input logic [3:0] sel, input logic alu,
                                       input logic [1:0] idx, input logic [3:0] add,
                                       input logic en, input logic bsy, input logic ill);
        return {fr, rl, sel, alu, idx, add, en, bsy, ill};
    endfunction

    task automatic check(input string tag, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    typedef struct {
        logic [31:0]      op;
        logic [2:0][3:0]  rl;
        logic [2:0][3:0]  sel;
        logic [3:0]       num;
        int               n;
        logic             exp_en;
        logic [3:0]       exp_add;
    } vec_t;

    vec_t tbl[6];

    task automatic drive_codes(input logic [2:0][3:0] rl, input logic [2:0][3:0] sel,
                               input logic [3:0] num);
        reg_load_1 = rl[0]; reg_load_2 = rl[1]; reg_load_3 = rl[2];
        select_1   = sel[0]; select_2  = sel[1]; select_3  = sel[2];
        num_of_ope = num;
    endtask

    logic [18:0] idle_fetch;
    logic [18:0] zero;
    logic [2:0][3:0] rlv, selv;

    initial begin
        idle_fetch = mk(1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        zero       = '0;
        tbl[0] = '{op: 32'hb8000005, rl: {4'h0, 4'h0, 4'h3}, sel: {4'h0, 4'h0, 4'h3},
                   num: 4'h5, n: 1, exp_en: 1'b1, exp_add: 4'h5};
        tbl[1] = '{op: 32'h55123456, rl: {4'h0, 4'h1, 4'h1}, sel: {4'h0, 4'h1, 4'h2},
                   num: 4'h1, n: 2, exp_en: 1'b1, exp_add: 4'h1};
        tbl[2] = '{op: 32'hc3000000, rl: {4'h0, 4'h2, 4'h4}, sel: {4'h0, 4'h2, 4'h4},
                   num: 4'h1, n: 2, exp_en: 1'b0, exp_add: 4'h0};
        tbl[3] = '{op: 32'h89abcdef, rl: {4'h0, 4'h0, 4'h7}, sel: {4'h0, 4'h0, 4'h9},
                   num: 4'h2, n: 1, exp_en: 1'b1, exp_add: 4'h2};
        tbl[4] = '{op: 32'h5d000000, rl: {4'h0, 4'h6, 4'h5}, sel: {4'h0, 4'h8, 4'ha},
                   num: 4'h3, n: 2, exp_en: 1'b1, exp_add: 4'h3};
        tbl[5] = '{op: 32'he2000000, rl: {4'h4, 4'h2, 4'h1}, sel: {4'h3, 4'h2, 4'h1},
                   num: 4'h2, n: 3, exp_en: 1'b0, exp_add: 4'h0};

        reset = 1'b0;
        fetch_ack = 1'b0;
        ope = 32'h0;
        rlv = '0;
        selv = '0;
        drive_codes(rlv, selv, 4'h0);
        tick();
        tick();
        check("reset_dut0", obs0, zero);
        check("reset_dut2", obs2, zero);
        reset = 1'b1;
        tick();
        check("first_fetch_req", obs0, idle_fetch);

        // Table of legal instructions on the STEP_WAIT=0 instance.
        for (int e = 0; e < 6; e++) begin
            ope = tbl[e].op;
            drive_codes(tbl[e].rl, tbl[e].sel, tbl[e].num);
            check($sformatf("v%0d_fetch", e), obs0, idle_fetch);
            fetch_ack = 1'b1;
            tick();
            fetch_ack = 1'b0;
            check($sformatf("v%0d_decode", e), obs0,
                  mk(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0));
            for (int k = 1; k <= tbl[e].n; k++) begin
                tick();
                check($sformatf("v%0d_step%0d", e, k), obs0,
                      mk(1'b0, tbl[e].rl[k-1], tbl[e].sel[k-1], 1'b1, 2'(k), 4'h0,
                         1'b0, 1'b1, 1'b0));
            end
            tick();
            check($sformatf("v%0d_advance", e), obs0,
                  mk(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, tbl[e].exp_add, tbl[e].exp_en,
                     1'b1, 1'b0));
            tick();
            check($sformatf("v%0d_refetch", e), obs0, idle_fetch);
        end

        // Unknown opcode.
        ope = 32'hff000000;
        rlv = {4'h3, 4'h2, 4'h1};
        selv = {4'h3, 4'h2, 4'h1};
        drive_codes(rlv, selv, 4'h7);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        check("ill_decode", obs0, mk(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1));
`ifdef SEQ_ILLEGAL_TRAP_EN
        for (int c = 0; c < 4; c++) begin
            fetch_ack = (c == 1);
            tick();
            check($sformatf("ill_halt%0d", c), obs0,
                  mk(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1));
        end
        fetch_ack = 1'b0;
`else
        tick();
        check("ill_advance", obs0, mk(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h1, 1'b1, 1'b1, 1'b0));
        tick();
        check("ill_refetch", obs0, idle_fetch);
`endif
        reset = 1'b0;
        tick();
        check("ill_reset", obs0, zero);
        reset = 1'b1;
        tick();
        check("ill_release", obs0, idle_fetch);
        check("w_fetch", obs2, idle_fetch);

        // Three steps of three cycles each on the STEP_WAIT=2 instance.
        ope = 32'he2000000;
        rlv = {4'h4, 4'h6, 4'h5};
        selv = {4'h9, 4'h8, 4'h7};
        drive_codes(rlv, selv, 4'h2);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        check("w_decode", obs2, mk(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0));
        for (int j = 1; j <= 9; j++) begin
            tick();
            check($sformatf("w_cyc%0d", j), obs2,
                  mk(1'b0, rlv[(j-1)/3], selv[(j-1)/3], (j % 3) == 0, 2'((j-1)/3 + 1),
                     4'h0, 1'b0, 1'b1, 1'b0));
        end
        tick();
        check("w_advance", obs2, mk(1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0));
        tick();
        check("w_refetch", obs2, idle_fetch);

        // Reset in the middle of step 2 of opcode 55.
        check("ab_fetch", obs0, idle_fetch);
        ope = 32'h55000000;
        rlv = {4'h0, 4'h1, 4'h1};
        selv = {4'h0, 4'h1, 4'h2};
        drive_codes(rlv, selv, 4'h1);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        tick();
        check("ab_step1", obs0, mk(1'b0, 4'h1, 4'h2, 1'b1, 2'd1, 4'h0, 1'b0, 1'b1, 1'b0));
        tick();
        check("ab_step2", obs0, mk(1'b0, 4'h1, 4'h1, 1'b1, 2'd2, 4'h0, 1'b0, 1'b1, 1'b0));
        reset = 1'b0;
        tick();
        check("ab_reset", obs0, zero);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("ab_after%0d", c), obs0, idle_fetch);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
